dual_port_blockram_flush: RTL and testbench

//  Simple dual-port blockram (1 read + 1 write port, one clock) with per-byte write enables,

---
 rtl/blockram_pkg.sv | 29 ++
 rtl/blockram_storage.sv | 51 +++++
 rtl/dual_port_blockram_flush.sv | 164 ++++++++++++++++
 tb/tb_dual_port_blockram_flush.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blockram_pkg.sv
// Shared types, widths and the byte-merge helper for the flushable dual-port blockram.
package blockram_pkg;

  typedef enum logic {
    BRAM_IDLE,
    BRAM_CLEAR
  } blockram_state_t;

  localparam int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = 64;
  localparam int unsigned BYTE_EN_WIDTH_IN_BITS       = SINGLE_ELEMENT_SIZE_IN_BITS / 8;

  // Widest element the merge helper supports; callers cast in and out at their own width.
  localparam int unsigned MERGE_MAX_BITS  = 1024;
  localparam int unsigned MERGE_MAX_BYTES = MERGE_MAX_BITS / 8;

  function automatic logic [MERGE_MAX_BITS-1:0] merge_bytes(
    input logic [MERGE_MAX_BITS-1:0]  old_word,
    input logic [MERGE_MAX_BITS-1:0]  new_word,
    input logic [MERGE_MAX_BYTES-1:0] mask
  );
    logic [MERGE_MAX_BITS-1:0] result;
    result = old_word;
    for (int unsigned b = 0; b < MERGE_MAX_BYTES; b++) begin
      if (mask[b]) result[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/blockram_storage.sv
// Inferable simple dual-port array: byte-masked write port, registered read port,
// and a registered read-first port on the write address that supplies the evicted word.
module blockram_storage #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH/8-1:0]   wr_byte_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  input  logic                 ev_en,
  output logic [WIDTH-1:0]     ev_data
);

  localparam int unsigned BYTES = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
  assign wr_ok = {1'b0, wr_addr} < (ADDR_W+1)'(DEPTH);
  assign rd_ok = {1'b0, rd_addr} < (ADDR_W+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wr_byte_en[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Both ports sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      ev_data <= '0;
    end else begin
      if (rd_en) rd_data <= rd_ok ? mem[rd_addr] : INIT_VALUE;
      if (ev_en) ev_data <= wr_ok ? mem[wr_addr] : INIT_VALUE;
    end
  end

endmodule

// File: rtl/dual_port_blockram_flush.sv
// Flushable simple dual-port blockram with byte enables, evict output and a hardware clear sweep.
// Optional same-address write-first forwarding: define DUAL_PORT_BLOCKRAM_BYPASS_EN.
module dual_port_blockram_flush
  import blockram_pkg::*;
#(
  parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int unsigned NUMBER_SETS                 = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS       = 6,
  parameter logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] INIT_VALUE = '0
) (
  input  logic                                     clk_in,
  input  logic                                     reset_in,
  input  logic                                     flush_req_in,
  output logic                                     busy_out,
  input  logic                                     read_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]         read_set_addr_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   read_element_out,
  output logic                                     read_valid_out,
  input  logic                                     write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]         write_set_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS/8-1:0] write_byte_en_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   write_element_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   evict_element_out,
  output logic                                     evict_valid_out
);

  localparam int unsigned W     = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int unsigned AW    = SET_PTR_WIDTH_IN_BITS;
  localparam int unsigned BYTES = W / 8;

  blockram_state_t  state_q, state_d;
  logic [AW-1:0]    clear_ptr_q, clear_ptr_d;
  logic             clearing;
  logic             rd_go;
  logic             wr_go;
  logic             mem_wr_en;
  logic [AW-1:0]    mem_wr_addr;
  logic [BYTES-1:0] mem_wr_be;
  logic [W-1:0]     mem_wr_data;
  logic [W-1:0]     rd_data;

  assign clearing = (state_q == BRAM_CLEAR);
  assign busy_out = clearing;
  assign rd_go    = !clearing && read_en_in;
  assign wr_go    = !clearing && write_en_in;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= BRAM_CLEAR;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  // Clear sweep: one set per cycle, leaving after the last set is written.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    case (state_q)
      BRAM_CLEAR: begin
        if (clear_ptr_q == AW'(NUMBER_SETS - 1)) begin
          state_d     = BRAM_IDLE;
          clear_ptr_d = '0;
        end else begin
          clear_ptr_d = clear_ptr_q + AW'(1);
        end
      end
      BRAM_IDLE: begin
        if (flush_req_in) begin
          state_d     = BRAM_CLEAR;
          clear_ptr_d = '0;
        end
      end
      default: begin
        state_d     = BRAM_CLEAR;
        clear_ptr_d = '0;
      end
    endcase
  end

  // Write-port mux: the sweep owns the port while clearing.
  assign mem_wr_en   = clearing || wr_go;
  assign mem_wr_addr = clearing ? clear_ptr_q : write_set_addr_in;
  assign mem_wr_be   = clearing ? '1 : write_byte_en_in;
  assign mem_wr_data = clearing ? INIT_VALUE : write_element_in;

  blockram_storage #(
    .WIDTH      (W),
    .DEPTH      (NUMBER_SETS),
    .ADDR_W     (AW),
    .INIT_VALUE (INIT_VALUE)
  ) u_storage (
    .clk        (clk_in),
    .rst_n      (reset_in),
    .wr_en      (mem_wr_en),
    .wr_addr    (mem_wr_addr),
    .wr_byte_en (mem_wr_be),
    .wr_data    (mem_wr_data),
    .rd_en      (rd_go),
    .rd_addr    (read_set_addr_in),
    .rd_data    (rd_data),
    .ev_en      (wr_go),
    .ev_data    (evict_element_out)
  );

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      read_valid_out  <= 1'b0;
      evict_valid_out <= 1'b0;
    end else begin
      read_valid_out  <= rd_go;
      evict_valid_out <= wr_go;
    end
  end

`ifdef DUAL_PORT_BLOCKRAM_BYPASS_EN
  logic             wr_in_range;
  logic             hit_c;
  logic             bypass_q;
  logic             held_sel_q;
  logic [W-1:0]     fwd_data_q;
  logic [BYTES-1:0] fwd_mask_q;
  logic [W-1:0]     held_q;
  logic [W-1:0]     merged_c;

  assign wr_in_range = {1'b0, write_set_addr_in} < (AW+1)'(NUMBER_SETS);
  assign hit_c = rd_go && wr_go && wr_in_range && (read_set_addr_in == write_set_addr_in);

  // Old word arrives on the evict port one cycle later; merge the captured write into it.
  assign merged_c = W'(merge_bytes(MERGE_MAX_BITS'(evict_element_out),
                                   MERGE_MAX_BITS'(fwd_data_q),
                                   MERGE_MAX_BYTES'(fwd_mask_q)));

  // The forwarded word is frozen into held_q so later evicts cannot disturb a held read.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      bypass_q   <= 1'b0;
      held_sel_q <= 1'b0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
      held_q     <= '0;
    end else begin
      bypass_q <= hit_c;
      if (hit_c) begin
        fwd_data_q <= write_element_in;
        fwd_mask_q <= write_byte_en_in;
      end
      if (rd_go) begin
        held_sel_q <= 1'b0;
      end else if (bypass_q) begin
        held_sel_q <= 1'b1;
        held_q     <= merged_c;
      end
    end
  end

  assign read_element_out = bypass_q ? merged_c : (held_sel_q ? held_q : rd_data);
`else
  assign read_element_out = rd_data;
`endif

endmodule

// File: tb/tb_dual_port_blockram_flush.sv
// Directed self-checking bench for dual_port_blockram_flush (default 64 x 64-bit build).
module tb_dual_port_blockram_flush;

  localparam int unsigned W  = 64;
  localparam int unsigned AW = 6;
  localparam int unsigned BW = 8;
  localparam int unsigned N  = 64;

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          flush_req_in = 1'b0;
  logic          busy_out;
  logic          read_en_in = 1'b0;
  logic [AW-1:0] read_set_addr_in = '0;
  logic [W-1:0]  read_element_out;
  logic          read_valid_out;
  logic          write_en_in = 1'b0;
  logic [AW-1:0] write_set_addr_in = '0;
  logic [BW-1:0] write_byte_en_in = '0;
  logic [W-1:0]  write_element_in = '0;
  logic [W-1:0]  evict_element_out;
  logic          evict_valid_out;

  int checks   = 0;
  int failures = 0;

  dual_port_blockram_flush dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .flush_req_in      (flush_req_in),
    .busy_out          (busy_out),
    .read_en_in        (read_en_in),
    .read_set_addr_in  (read_set_addr_in),
    .read_element_out  (read_element_out),
    .read_valid_out    (read_valid_out),
    .write_en_in       (write_en_in),
    .write_set_addr_in (write_set_addr_in),
    .write_byte_en_in  (write_byte_en_in),
    .write_element_in  (write_element_in),
    .evict_element_out (evict_element_out),
    .evict_valid_out   (evict_valid_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    flush_req_in = 1'b0;
    read_en_in   = 1'b0;
    write_en_in  = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [BW-1:0] m);
    write_en_in = 1'b1; write_set_addr_in = a; write_element_in = d; write_byte_en_in = m;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    read_en_in = 1'b1; read_set_addr_in = a;
  endtask

  // Counts consecutive samples (starting now) with busy_out high; bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_out && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    reset_in = 1'b1;
    #2 reset_in = 1'b0;
    #1;
    checks++;
    if (busy_out !== 1'b1 || read_valid_out !== 1'b0 || evict_valid_out !== 1'b0 ||
        read_element_out !== '0 || evict_element_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b rv=%b ev=%b rd=%h evd=%h, expected busy=1 rest 0",
               busy_out, read_valid_out, evict_valid_out, read_element_out, evict_element_out);
    end
    repeat (3) tick();
    reset_in = 1'b1;
    count_busy(n);
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL reset_busy_len got=%0d expected=64", n);
    end
    for (int a = 0; a < int'(N); a++) begin
      do_read(AW'(a));
      tick();
      checks++;
      if (read_valid_out !== 1'b1 || read_element_out !== '0) begin
        failures++;
        $display("FAIL reset_read_set%0d rv=%b data=%h expected rv=1 data=0", a, read_valid_out, read_element_out);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (read_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL read_valid_drop got=%b expected=0", read_valid_out);
    end
  endtask

  task automatic test_byte_merge();
    do_write(6'd5, 64'h1122334455667788, 8'hFF);
    tick();
    checks++;
    if (evict_valid_out !== 1'b1 || evict_element_out !== 64'h0) begin
      failures++;
      $display("FAIL merge_first_evict ev=%b data=%h expected ev=1 data=0", evict_valid_out, evict_element_out);
    end
    do_write(6'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    tick();
    checks++;
    if (evict_valid_out !== 1'b1 || evict_element_out !== 64'h1122334455667788) begin
      failures++;
      $display("FAIL merge_second_evict ev=%b data=%h expected ev=1 data=1122334455667788",
               evict_valid_out, evict_element_out);
    end
    do_write(6'd5, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    tick();
    checks++;
    if (evict_valid_out !== 1'b1 || evict_element_out !== 64'h11223344AAAAAAAA) begin
      failures++;
      $display("FAIL zero_mask_evict ev=%b data=%h expected ev=1 data=11223344aaaaaaaa",
               evict_valid_out, evict_element_out);
    end
    idle_inputs();
    do_read(6'd5);
    tick();
    checks++;
    if (read_valid_out !== 1'b1 || read_element_out !== 64'h11223344AAAAAAAA || evict_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL merge_read rv=%b data=%h ev=%b expected rv=1 data=11223344aaaaaaaa ev=0",
               read_valid_out, read_element_out, evict_valid_out);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_same_addr();
    logic [W-1:0] exp_rd;
`ifdef DUAL_PORT_BLOCKRAM_BYPASS_EN
    exp_rd = 64'h2;
`else
    exp_rd = 64'h1;
`endif
    do_write(6'd9, 64'h1, 8'hFF);
    tick();
    do_write(6'd9, 64'h2, 8'hFF);
    do_read(6'd9);
    tick();
    checks++;
    if (read_valid_out !== 1'b1 || read_element_out !== exp_rd) begin
      failures++;
      $display("FAIL same_addr_read rv=%b data=%h expected rv=1 data=%h", read_valid_out, read_element_out, exp_rd);
    end
    checks++;
    if (evict_valid_out !== 1'b1 || evict_element_out !== 64'h1) begin
      failures++;
      $display("FAIL same_addr_evict ev=%b data=%h expected ev=1 data=1", evict_valid_out, evict_element_out);
    end
    idle_inputs();
    do_write(6'd12, 64'h77, 8'hFF);
    tick();
    checks++;
    if (read_valid_out !== 1'b0 || read_element_out !== exp_rd) begin
      failures++;
      $display("FAIL read_hold rv=%b data=%h expected rv=0 data=%h", read_valid_out, read_element_out, exp_rd);
    end
    idle_inputs();
    do_read(6'd9);
    tick();
    checks++;
    if (read_element_out !== 64'h2) begin
      failures++;
      $display("FAIL same_addr_after data=%h expected=2", read_element_out);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    int n;
    for (int a = 0; a < int'(N); a++) begin
      do_write(AW'(a), 64'hC0DE000000000100 + 64'(a), 8'hFF);
      tick();
    end
    idle_inputs();
    flush_req_in = 1'b1;
    do_write(6'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    tick();
    idle_inputs();
    checks++;
    if (evict_valid_out !== 1'b1 || evict_element_out !== 64'hC0DE000000000103) begin
      failures++;
      $display("FAIL flush_write_evict ev=%b data=%h expected ev=1 data=c0de000000000103",
               evict_valid_out, evict_element_out);
    end
    count_busy(n);
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL flush_busy_len got=%0d expected=64", n);
    end
    for (int a = 0; a < int'(N); a++) begin
      do_read(AW'(a));
      tick();
      checks++;
      if (read_valid_out !== 1'b1 || read_element_out !== '0) begin
        failures++;
        $display("FAIL flush_read_set%0d rv=%b data=%h expected rv=1 data=0", a, read_valid_out, read_element_out);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    do_write(6'd10, 64'hDEADBEEF0000000A, 8'hFF);
    tick();
    idle_inputs();
    flush_req_in = 1'b1;
    do_read(6'd10);
    do_write(6'd11, 64'h5555, 8'hFF);
    tick();
    idle_inputs();
    checks++;
    if (read_valid_out !== 1'b1 || read_element_out !== 64'hDEADBEEF0000000A || evict_valid_out !== 1'b1) begin
      failures++;
      $display("FAIL flush_cycle_read rv=%b data=%h ev=%b expected rv=1 data=deadbeef0000000a ev=1",
               read_valid_out, read_element_out, evict_valid_out);
    end
    repeat (20) tick();
    checks++;
    if (busy_out !== 1'b1 || read_element_out !== 64'hDEADBEEF0000000A || read_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL sweep_hold busy=%b data=%h rv=%b expected busy=1 data=deadbeef0000000a rv=0",
               busy_out, read_element_out, read_valid_out);
    end
    reset_in = 1'b0;
    #1;
    checks++;
    if (busy_out !== 1'b1 || read_valid_out !== 1'b0 || evict_valid_out !== 1'b0 ||
        read_element_out !== '0 || evict_element_out !== '0) begin
      failures++;
      $display("FAIL midsweep_reset busy=%b rv=%b ev=%b rd=%h evd=%h expected busy=1 rest 0",
               busy_out, read_valid_out, evict_valid_out, read_element_out, evict_element_out);
    end
    tick();
    tick();
    reset_in = 1'b1;
    count_busy(n);
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL restart_busy_len got=%0d expected=64", n);
    end
    do_read(6'd10);
    tick();
    checks++;
    if (read_valid_out !== 1'b1 || read_element_out !== '0) begin
      failures++;
      $display("FAIL restart_read rv=%b data=%h expected rv=1 data=0", read_valid_out, read_element_out);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_sweep_ignore();
    int n;
    int viol;
    flush_req_in = 1'b1;
    tick();
    flush_req_in = 1'b1;
    do_read(6'd7);
    do_write(6'd7, 64'hDEAD, 8'hFF);
    n = 0;
    viol = 0;
    while (busy_out && n < 200) begin
      n++;
      tick();
      if (read_valid_out !== 1'b0 || evict_valid_out !== 1'b0) viol++;
    end
    idle_inputs();
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL sweep_valid_pulses got=%0d expected=0", viol);
    end
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL sweep_ignore_busy_len got=%0d expected=64", n);
    end
    do_read(6'd7);
    tick();
    checks++;
    if (read_valid_out !== 1'b1 || read_element_out !== '0) begin
      failures++;
      $display("FAIL sweep_ignore_read rv=%b data=%h expected rv=1 data=0", read_valid_out, read_element_out);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_byte_merge();
    test_same_addr();
    test_flush();
    test_reset_mid_sweep();
    test_sweep_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
